instr_mem_loader: RTL and testbench

//  Write-side counterpart of the pipeline's instruction decode path: takes the byte stream

---
 rtl/instr_mem_loader.sv | 139 +++++++++++++
 tb/tb_instr_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Packs the byte stream from the debug UART receiver into 32-bit MIPS
//   instructions and writes them to instruction memory at consecutive word
//   addresses starting at 0. The load ends when the HALT instruction has been
//   written, or when the last memory word has been written (overflow).
//
// Ports
//   i_clk        : system clock, rising edge
//   i_reset      : asynchronous reset, active-high
//   i_start      : 1-cycle pulse, start a new load at address 0 (ignored while busy)
//   i_rx_data    : received byte
//   i_rx_done    : 1-cycle strobe, i_rx_data valid
//   o_wr_en      : instruction memory write enable, 1-cycle pulse
//   o_wr_addr    : word address of the write (held between writes)
//   o_wr_data    : instruction word being written (held between writes)
//   o_busy       : high while receiving or writing
//   o_done       : level, load finished
//   o_overflow   : level, load ended because memory filled without HALT
//   o_word_count : number of words written in the current/last load

module instr_mem_loader #(
  parameter int          N_BITS  = 32,
  parameter int          N_BYTE  = 8,
  parameter int          N_ADDR  = 10,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [N_BYTE-1:0] i_rx_data,
  input  logic              i_rx_done,
  output logic              o_wr_en,
  output logic [N_ADDR-1:0] o_wr_addr,
  output logic [N_BITS-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [N_ADDR:0]   o_word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N_ADDR-1:0] LAST_ADDR  = '1;
  localparam logic [N_ADDR-1:0] ADDR_ONE   = {{(N_ADDR-1){1'b0}}, 1'b1};
  localparam logic [N_ADDR:0]   COUNT_ONE  = {{N_ADDR{1'b0}}, 1'b1};

  state_t            state;
  logic [1:0]        byte_idx;
  logic [N_BITS-1:0] asm_word;
  logic [N_ADDR-1:0] addr;
  logic [N_BITS-1:0] shifted;
  logic              is_halt;
  logic              is_last;

  // Earlier bytes move towards the MSB, so the first byte of a word ends up
  // in [31:24] and the fourth in [7:0].
  assign shifted = {asm_word[N_BITS-N_BYTE-1:0], i_rx_data};

  // End-of-load conditions, evaluated on the word currently being written.
  assign is_halt = (o_wr_data[N_BITS-1 -: 6] == HALT_OP);
  assign is_last = (o_wr_addr == LAST_ADDR);

  // Loader FSM. All outputs are registered; o_wr_en is high exactly for the
  // WRITE cycle. 'addr' is the next free word, while o_wr_addr is latched
  // together with o_wr_data so both stay stable between writes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      asm_word     <= '0;
      addr         <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state        <= RECV;
            byte_idx     <= 2'd0;
            addr         <= '0;
            o_wr_addr    <= '0;
            o_word_count <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
          end
        end

        RECV: begin
          if (i_rx_done) begin
            asm_word <= shifted;
            if (byte_idx == 2'd3) begin
              byte_idx  <= 2'd0;
              o_wr_data <= shifted;
              o_wr_addr <= addr;
              o_wr_en   <= 1'b1;
              state     <= WRITE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        WRITE: begin
          o_word_count <= o_word_count + COUNT_ONE;
          if (is_halt || is_last) begin
            // A byte arriving in a load-ending WRITE cycle is dropped.
            state      <= DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_overflow <= !is_halt;
          end else begin
            addr  <= addr + ADDR_ONE;
            state <= RECV;
            // A byte arriving during WRITE starts the next word.
            if (i_rx_done) begin
              asm_word <= shifted;
              byte_idx <= 2'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader. A default instance (N_ADDR=10)
//   covers HALT-terminated loads, back-to-back bytes, reset and ignored
//   inputs; a second instance with N_ADDR=2 covers the memory-full case.
//   Inputs change on the falling edge and outputs are read there too.

module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, overflow;
  logic [10:0] word_count;

  logic        start2 = 1'b0;
  logic [7:0]  rx_data2 = 8'h00;
  logic        rx_done2 = 1'b0;
  logic        wr_en2;
  logic [1:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic        busy2, done2, overflow2;
  logic [2:0]  word_count2;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;

  instr_mem_loader dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_overflow(overflow),
    .o_word_count(word_count)
  );

  instr_mem_loader #(.N_ADDR(2)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_start(start2),
    .i_rx_data(rx_data2), .i_rx_done(rx_done2),
    .o_wr_en(wr_en2), .o_wr_addr(wr_addr2), .o_wr_data(wr_data2),
    .o_busy(busy2), .o_done(done2), .o_overflow(overflow2),
    .o_word_count(word_count2)
  );

  // 100 MHz style free-running clock.
  always #5 clk = ~clk;

  // Counts write pulses on the main instance, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) writes_seen++;
  end

  task automatic strobe(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe(b);
    rx_done = 1'b0;
  endtask

  task automatic quiet();
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte2(input logic [7:0] b);
    rx_data2 = b;
    rx_done2 = 1'b1;
    @(negedge clk);
    rx_done2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({wr_en, wr_addr, wr_data, busy, done, overflow, word_count} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d want all 0",
               wr_en, wr_addr, wr_data, busy, done, overflow, word_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_halt_load();
    int ws;
    ws = writes_seen;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL t1_busy: got %b want 1", busy); end
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd0, 32'h20080005}) begin
      bad++;
      $display("[TB] FAIL t1_write0: got en=%b addr=%0d data=%h want en=1 addr=0 data=20080005", wr_en, wr_addr, wr_data);
    end
    send_byte(8'hFC);
    total++;
    if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL t1_pulse_width: got en=%b want 0", wr_en); end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd1, 32'hFC000000}) begin
      bad++;
      $display("[TB] FAIL t1_write1: got en=%b addr=%0d data=%h want en=1 addr=1 data=fc000000", wr_en, wr_addr, wr_data);
    end
    quiet();
    total++;
    if ({done, overflow, busy, word_count} !== {1'b1, 1'b0, 1'b0, 11'd2}) begin
      bad++;
      $display("[TB] FAIL t1_end: got done=%b ovf=%b busy=%b cnt=%0d want done=1 ovf=0 busy=0 cnt=2", done, overflow, busy, word_count);
    end
    total++;
    if (writes_seen - ws !== 2) begin bad++; $display("[TB] FAIL t1_write_count: got %0d want 2", writes_seen - ws); end
  endtask

  task automatic test_back_to_back();
    pulse_start();
    total++;
    if ({done, busy} !== 2'b01) begin bad++; $display("[TB] FAIL t3_restart: got done=%b busy=%b want done=0 busy=1", done, busy); end
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd0, 32'h11223344}) begin
      bad++;
      $display("[TB] FAIL t3_write0: got en=%b addr=%0d data=%h want en=1 addr=0 data=11223344", wr_en, wr_addr, wr_data);
    end
    strobe(8'hAB); strobe(8'hCD); strobe(8'hEF); strobe(8'h01);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd1, 32'hABCDEF01}) begin
      bad++;
      $display("[TB] FAIL t3_write1: got en=%b addr=%0d data=%h want en=1 addr=1 data=abcdef01", wr_en, wr_addr, wr_data);
    end
    strobe(8'hFC); strobe(8'h00); strobe(8'h00); strobe(8'h00);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd2, 32'hFC000000}) begin
      bad++;
      $display("[TB] FAIL t3_write2: got en=%b addr=%0d data=%h want en=1 addr=2 data=fc000000", wr_en, wr_addr, wr_data);
    end
    strobe(8'h77);
    rx_done = 1'b0;
    total++;
    if ({done, word_count} !== {1'b1, 11'd3}) begin
      bad++;
      $display("[TB] FAIL t3_end: got done=%b cnt=%0d want done=1 cnt=3", done, word_count);
    end
  endtask

  task automatic test_restart();
    int ws;
    ws = writes_seen;
    pulse_start();
    total++;
    if ({done, overflow, busy, word_count} !== {1'b0, 1'b0, 1'b1, 11'd0}) begin
      bad++;
      $display("[TB] FAIL t6_restart: got done=%b ovf=%b busy=%b cnt=%0d want 0 0 1 0", done, overflow, busy, word_count);
    end
    send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd0, 32'hFC000007}) begin
      bad++;
      $display("[TB] FAIL t6_write: got en=%b addr=%0d data=%h want en=1 addr=0 data=fc000007", wr_en, wr_addr, wr_data);
    end
    quiet();
    total++;
    if ({done, word_count, 32'(writes_seen - ws)} !== {1'b1, 11'd1, 32'd1}) begin
      bad++;
      $display("[TB] FAIL t6_end: got done=%b cnt=%0d writes=%0d want done=1 cnt=1 writes=1", done, word_count, writes_seen - ws);
    end
  endtask

  task automatic test_reset_midword();
    int ws;
    pulse_start();
    send_byte(8'hAA); send_byte(8'hBB);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({wr_en, wr_addr, wr_data, busy, done, overflow, word_count} !== '0) begin
      bad++;
      $display("[TB] FAIL t4_async_reset: got en=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d want all 0",
               wr_en, wr_addr, wr_data, busy, done, overflow, word_count);
    end
    @(negedge clk);
    rst = 1'b0;
    ws = writes_seen;
    quiet();
    pulse_start();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd0, 32'h12345678}) begin
      bad++;
      $display("[TB] FAIL t4_first_write: got en=%b addr=%0d data=%h want en=1 addr=0 data=12345678", wr_en, wr_addr, wr_data);
    end
    total++;
    if (writes_seen - ws !== 1) begin bad++; $display("[TB] FAIL t4_write_count: got %0d want 1", writes_seen - ws); end
    quiet();
    send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    quiet();
    total++;
    if ({done, word_count} !== {1'b1, 11'd2}) begin
      bad++;
      $display("[TB] FAIL t4_end: got done=%b cnt=%0d want done=1 cnt=2", done, word_count);
    end
  endtask

  task automatic test_ignored();
    int ws;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ws = writes_seen;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    quiet();
    total++;
    if ({busy, word_count, 32'(writes_seen - ws)} !== {1'b0, 11'd0, 32'd0}) begin
      bad++;
      $display("[TB] FAIL t5_idle_bytes: got busy=%b cnt=%0d writes=%0d want 0 0 0", busy, word_count, writes_seen - ws);
    end
    pulse_start();
    send_byte(8'h01); send_byte(8'h02);
    pulse_start();
    send_byte(8'h03); send_byte(8'h04);
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 10'd0, 32'h01020304}) begin
      bad++;
      $display("[TB] FAIL t5_start_in_recv: got en=%b addr=%0d data=%h want en=1 addr=0 data=01020304", wr_en, wr_addr, wr_data);
    end
    quiet();
    send_byte(8'hFF); send_byte(8'hEE); send_byte(8'hDD); send_byte(8'hCC);
    quiet();
    ws = writes_seen;
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    quiet();
    total++;
    if ({done, wr_addr, word_count, wr_data, 32'(writes_seen - ws)} !== {1'b1, 10'd1, 11'd2, 32'hFFEEDDCC, 32'd0}) begin
      bad++;
      $display("[TB] FAIL t5_done_bytes: got done=%b addr=%0d cnt=%0d data=%h writes=%0d want 1 1 2 ffeeddcc 0",
               done, wr_addr, word_count, wr_data, writes_seen - ws);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = 32'h0A0B0C00 | 32'(i);
      send_byte2(w[31:24]); send_byte2(w[23:16]); send_byte2(w[15:8]); send_byte2(w[7:0]);
      total++;
      if ({wr_en2, wr_addr2, wr_data2} !== {1'b1, 2'(i), w}) begin
        bad++;
        $display("[TB] FAIL t2_write%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h", i, wr_en2, wr_addr2, wr_data2, i, w);
      end
    end
    @(negedge clk);
    total++;
    if ({done2, overflow2, busy2, word_count2} !== {1'b1, 1'b1, 1'b0, 3'd4}) begin
      bad++;
      $display("[TB] FAIL t2_end: got done=%b ovf=%b busy=%b cnt=%0d want done=1 ovf=1 busy=0 cnt=4", done2, overflow2, busy2, word_count2);
    end
  endtask

  // Scenario sequence; every step runs a fixed number of cycles.
  initial begin
    @(negedge clk);
    test_reset();
    test_halt_load();
    test_back_to_back();
    test_restart();
    test_reset_midword();
    test_ignored();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
